// File: rtl/reg_writeback_if.sv
// Register writeback bus: ALU results, load issue/response handshake,
// register-file write port and scoreboard/status outputs.
interface reg_writeback_if #(
  parameter int unsigned ADDR_BUS_WIDTH = 5,
  parameter int unsigned DATA_BUS_WIDTH = 32,
  parameter int unsigned QUEUE_DEPTH    = 4
);
  localparam int unsigned NUM_REGS = 2 ** ADDR_BUS_WIDTH;
  localparam int unsigned CNT_W    = $clog2(QUEUE_DEPTH) + 1;

  logic                      alu_valid;
  logic [ADDR_BUS_WIDTH-1:0] alu_rd;
  logic [DATA_BUS_WIDTH-1:0] alu_data;
  logic                      ld_issue;
  logic [ADDR_BUS_WIDTH-1:0] ld_issue_rd;
  logic                      ld_valid;
  logic                      ld_ready;
  logic [ADDR_BUS_WIDTH-1:0] ld_rd;
  logic [DATA_BUS_WIDTH-1:0] ld_data;
  logic                      rf_write_en;
  logic [ADDR_BUS_WIDTH-1:0] rf_addr;
  logic [DATA_BUS_WIDTH-1:0] rf_write_data;
  logic [NUM_REGS-1:0]       busy;
  logic [CNT_W-1:0]          queue_count;

  // Core side: produces results and loads, observes the write port and scoreboard
  modport master (
    output alu_valid, alu_rd, alu_data, ld_issue, ld_issue_rd,
    output ld_valid, ld_rd, ld_data,
    input  ld_ready, rf_write_en, rf_addr, rf_write_data, busy, queue_count
  );

  // Writeback unit side
  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_issue, ld_issue_rd,
    input  ld_valid, ld_rd, ld_data,
    output ld_ready, rf_write_en, rf_addr, rf_write_data, busy, queue_count
  );
endinterface

// File: rtl/reg_writeback_unit.sv
// Register-file writeback arbiter: ALU results take priority over a small
// in-order load-response FIFO; keeps a per-register busy scoreboard for loads.
// Optional macro REG_WB_BYPASS_EN: a load accepted into an empty FIFO with no
// ALU write selected goes straight to the write port (1-cycle load latency).
module reg_writeback_unit #(
  parameter int unsigned ADDR_BUS_WIDTH = 5,
  parameter int unsigned DATA_BUS_WIDTH = 32,
  parameter int unsigned QUEUE_DEPTH    = 4
) (
  input  logic           clk,
  input  logic           rst,
  reg_writeback_if.slave wb
);
  localparam int unsigned NUM_REGS = 2 ** ADDR_BUS_WIDTH;
  localparam int unsigned PTR_W    = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_BUS_WIDTH-1:0] rd;
    logic [DATA_BUS_WIDTH-1:0] data;
  } ld_entry_t;

  ld_entry_t                 mem_q [QUEUE_DEPTH];
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic                      ld_ready_q, ld_ready_d;
  logic [NUM_REGS-1:0]       busy_q, busy_d;
  logic                      we_q, we_d;
  logic [ADDR_BUS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_BUS_WIDTH-1:0] wdata_q, wdata_d;

  logic      alu_sel, fifo_empty, ld_accept_nz, deq, enq, bypass;
  ld_entry_t head;

  // Source selection: ALU first, then FIFO head, then (optionally) bypass
  always_comb begin
    head         = mem_q[rd_ptr_q];
    alu_sel      = wb.alu_valid && (wb.alu_rd != '0);
    fifo_empty   = (count_q == '0);
    ld_accept_nz = wb.ld_valid && ld_ready_q && (wb.ld_rd != '0);
    deq          = !alu_sel && !fifo_empty;
`ifdef REG_WB_BYPASS_EN
    bypass       = ld_accept_nz && fifo_empty && !alu_sel;
`else
    bypass       = 1'b0;
`endif
    enq          = ld_accept_nz && !bypass;
  end

  // Next-state for FIFO bookkeeping, write port and scoreboard
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    busy_d     = busy_q;

    if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d    = count_q + CNT_W'(enq) - CNT_W'(deq);
    ld_ready_d = (count_d < CNT_W'(QUEUE_DEPTH));

    if (alu_sel) begin
      we_d    = 1'b1;
      addr_d  = wb.alu_rd;
      wdata_d = wb.alu_data;
    end else if (deq) begin
      we_d    = 1'b1;
      addr_d  = head.rd;
      wdata_d = head.data;
      busy_d[head.rd] = 1'b0;
    end else if (bypass) begin
      we_d    = 1'b1;
      addr_d  = wb.ld_rd;
      wdata_d = wb.ld_data;
      busy_d[wb.ld_rd] = 1'b0;
    end

    // A new issue to the same register overrides a same-cycle clear
    if (wb.ld_issue && (wb.ld_issue_rd != '0)) busy_d[wb.ld_issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Control and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ld_ready_q <= 1'b0;
      busy_q     <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ld_ready_q <= ld_ready_d;
      busy_q     <= busy_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  // FIFO storage; contents are only meaningful under count_q
  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr_q] <= '{rd: wb.ld_rd, data: wb.ld_data};
  end

  assign wb.ld_ready      = ld_ready_q;
  assign wb.rf_write_en   = we_q;
  assign wb.rf_addr       = addr_q;
  assign wb.rf_write_data = wdata_q;
  assign wb.busy          = busy_q;
  assign wb.queue_count   = count_q;
endmodule

// File: tb/tb_reg_writeback_unit.sv
// Directed bench for reg_writeback_unit.
module tb_reg_writeback_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   zero_writes = 0;

  always #5 clk = ~clk;

  reg_writeback_if bus ();

  reg_writeback_unit dut (
    .clk (clk),
    .rst (rst),
    .wb  (bus)
  );

  // Register 0 must never be written
  always @(negedge clk) begin
    if (bus.rf_write_en === 1'b1 && bus.rf_addr === 5'd0) zero_writes++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.alu_valid   = 1'b0;
    bus.alu_rd      = '0;
    bus.alu_data    = '0;
    bus.ld_issue    = 1'b0;
    bus.ld_issue_rd = '0;
    bus.ld_valid    = 1'b0;
    bus.ld_rd       = '0;
    bus.ld_data     = '0;

    // Reset state
    step;
    check("rst_we",    64'(bus.rf_write_en), 64'd0);
    check("rst_addr",  64'(bus.rf_addr), 64'd0);
    check("rst_data",  64'(bus.rf_write_data), 64'd0);
    check("rst_busy",  64'(bus.busy), 64'd0);
    check("rst_count", 64'(bus.queue_count), 64'd0);
    check("rst_ready", 64'(bus.ld_ready), 64'd0);
    step;
    rst = 1'b0;
    check("ready_low_at_release", 64'(bus.ld_ready), 64'd0);
    step;
    check("ready_after_release", 64'(bus.ld_ready), 64'd1);

    // Single ALU write
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'h0000_1234;
    step;
    bus.alu_valid = 1'b0;
    check("alu_we",   64'(bus.rf_write_en), 64'd1);
    check("alu_addr", 64'(bus.rf_addr), 64'd5);
    check("alu_data", 64'(bus.rf_write_data), 64'h1234);
    step;
    check("alu_we_off",    64'(bus.rf_write_en), 64'd0);
    check("alu_addr_hold", 64'(bus.rf_addr), 64'd5);
    check("alu_data_hold", 64'(bus.rf_write_data), 64'h1234);

    // Load issue, response and scoreboard clear
    bus.ld_issue = 1'b1; bus.ld_issue_rd = 5'd9;
    step;
    bus.ld_issue = 1'b0;
    check("busy9_set", 64'(bus.busy), 64'h200);
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd9; bus.ld_data = 32'h0000_2004;
    step;
    bus.ld_valid = 1'b0;
`ifdef REG_WB_BYPASS_EN
    check("ld9_we",   64'(bus.rf_write_en), 64'd1);
    check("ld9_addr", 64'(bus.rf_addr), 64'd9);
    check("ld9_data", 64'(bus.rf_write_data), 64'h2004);
    check("busy9_clr", 64'(bus.busy), 64'd0);
    check("ld9_count", 64'(bus.queue_count), 64'd0);
`else
    check("ld9_we_wait", 64'(bus.rf_write_en), 64'd0);
    check("busy9_held",  64'(bus.busy), 64'h200);
    check("ld9_count1",  64'(bus.queue_count), 64'd1);
    step;
    check("ld9_we",   64'(bus.rf_write_en), 64'd1);
    check("ld9_addr", 64'(bus.rf_addr), 64'd9);
    check("ld9_data", 64'(bus.rf_write_data), 64'h2004);
    check("busy9_clr", 64'(bus.busy), 64'd0);
    check("ld9_count0", 64'(bus.queue_count), 64'd0);
`endif

    // Starvation: ALU every cycle fills the FIFO
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h0000_3333;
    bus.ld_valid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.ld_rd = 5'(10 + k); bus.ld_data = 32'(32'hA0 + k);
      step;
      check("starve_alu_addr", 64'(bus.rf_addr), 64'd3);
    end
    check("full_count", 64'(bus.queue_count), 64'd4);
    check("full_ready", 64'(bus.ld_ready), 64'd0);
    bus.ld_rd = 5'd14; bus.ld_data = 32'h0000_00A4;
    step;
    check("full_count_hold", 64'(bus.queue_count), 64'd4);
    check("full_ready_hold", 64'(bus.ld_ready), 64'd0);
    check("full_alu_data",   64'(bus.rf_write_data), 64'h3333);
    bus.alu_valid = 1'b0;
    step;
    check("drain0_addr",  64'(bus.rf_addr), 64'd10);
    check("drain0_data",  64'(bus.rf_write_data), 64'hA0);
    check("drain0_count", 64'(bus.queue_count), 64'd3);
    check("drain0_ready", 64'(bus.ld_ready), 64'd1);
    step;
    bus.ld_valid = 1'b0;
    check("drain1_addr",  64'(bus.rf_addr), 64'd11);
    check("drain1_count", 64'(bus.queue_count), 64'd3);
    step;
    check("drain2_addr",  64'(bus.rf_addr), 64'd12);
    check("drain2_count", 64'(bus.queue_count), 64'd2);
    step;
    check("drain3_addr",  64'(bus.rf_addr), 64'd13);
    check("drain3_we",    64'(bus.rf_write_en), 64'd1);
    step;
    check("drain4_addr",  64'(bus.rf_addr), 64'd14);
    check("drain4_data",  64'(bus.rf_write_data), 64'hA4);
    check("drain4_count", 64'(bus.queue_count), 64'd0);
    step;
    check("drain_done_we", 64'(bus.rf_write_en), 64'd0);

    // Load response to register 0 is accepted and dropped
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd0; bus.ld_data = 32'h0000_0055;
    step;
    bus.ld_valid = 1'b0;
    check("ld0_count", 64'(bus.queue_count), 64'd0);
    check("ld0_we",    64'(bus.rf_write_en), 64'd0);
    step;
    check("ld0_we_late", 64'(bus.rf_write_en), 64'd0);

    // ALU rd=0 does not block the FIFO head
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h0000_3333;
    bus.ld_valid  = 1'b1; bus.ld_rd = 5'd7; bus.ld_data = 32'h0000_0077;
    step;
    check("q7_count", 64'(bus.queue_count), 64'd1);
    bus.ld_valid = 1'b0; bus.alu_rd = 5'd0; bus.alu_data = 32'h0000_DEAD;
    step;
    check("q7_we",   64'(bus.rf_write_en), 64'd1);
    check("q7_addr", 64'(bus.rf_addr), 64'd7);
    check("q7_data", 64'(bus.rf_write_data), 64'h77);
    step;
    bus.alu_valid = 1'b0;
    check("alu0_we",   64'(bus.rf_write_en), 64'd0);
    check("alu0_addr", 64'(bus.rf_addr), 64'd7);

    // Same-cycle set and clear of busy[4]: set wins
    bus.ld_issue = 1'b1; bus.ld_issue_rd = 5'd4;
    step;
    bus.ld_issue = 1'b0;
    check("busy4_set", 64'(bus.busy), 64'h10);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3;
    bus.ld_valid  = 1'b1; bus.ld_rd = 5'd4; bus.ld_data = 32'h0000_0044;
    step;
    check("q4_count", 64'(bus.queue_count), 64'd1);
    bus.alu_valid = 1'b0; bus.ld_valid = 1'b0;
    bus.ld_issue = 1'b1; bus.ld_issue_rd = 5'd4;
    step;
    bus.ld_issue = 1'b0;
    check("q4_addr",   64'(bus.rf_addr), 64'd4);
    check("q4_data",   64'(bus.rf_write_data), 64'h44);
    check("busy4_win", 64'(bus.busy), 64'h10);
    step;
    check("busy4_keep", 64'(bus.busy), 64'h10);

    // Reset mid-operation with three queued entries
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3;
    bus.ld_valid  = 1'b1;
    bus.ld_issue  = 1'b1; bus.ld_issue_rd = 5'd20;
    bus.ld_rd = 5'd20; bus.ld_data = 32'h0000_00C0;
    step;
    bus.ld_issue = 1'b0;
    bus.ld_rd = 5'd21; bus.ld_data = 32'h0000_00C1;
    step;
    bus.ld_rd = 5'd22; bus.ld_data = 32'h0000_00C2;
    step;
    check("pre_rst_count", 64'(bus.queue_count), 64'd3);
    check("pre_rst_busy",  64'(bus.busy), 64'h10_0010);
    bus.alu_valid = 1'b0; bus.ld_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_we",    64'(bus.rf_write_en), 64'd0);
    check("mid_rst_busy",  64'(bus.busy), 64'd0);
    check("mid_rst_count", 64'(bus.queue_count), 64'd0);
    check("mid_rst_ready", 64'(bus.ld_ready), 64'd0);
    step;
    step;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step;
      check("post_rst_we", 64'(bus.rf_write_en), 64'd0);
    end
    check("post_rst_addr",  64'(bus.rf_addr), 64'd0);
    check("post_rst_ready", 64'(bus.ld_ready), 64'd1);
    check("post_rst_count", 64'(bus.queue_count), 64'd0);

    check("no_reg0_write", 64'(zero_writes), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
